// File: rtl/vram_bus_arbiter.sv
// Single-owner sequencer for the asynchronous VRAM: arbitrates scan-out reads, CPU reads
// and write-FIFO drains onto one SRAM bus and drives its strobes and data tristate.
module vram_bus_arbiter #(
   parameter int ADDR_W    = 19,
   parameter int DATA_W    = 16,
   parameter int WR_CYCLES = 3,
   parameter int RD_CYCLES = 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              scan_req,
   input  logic [ADDR_W-1:0] scan_addr,
   output logic [DATA_W-1:0] scan_data,
   output logic              scan_valid,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_done,
   input  logic              wr_empty,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_read,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dq_out,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_in,
   output logic              sram_we_n,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              busy
);
   localparam int CNT_MAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
   localparam logic LAST_RD = 1'b0;
   localparam logic LAST_WR = 1'b1;

   typedef enum logic [2:0] {IDLE, SCAN_RD, CPU_RD, WR, WR_REC} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              last_cpu, last_cpu_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] dq_out_nxt, scan_data_nxt, rd_data_nxt;
   logic              scan_valid_nxt, rd_done_nxt, wr_read_nxt;
   logic              we_n_nxt, ce_n_nxt, oe_n_nxt, dq_oe_nxt;
   logic              wr_ok, rd_win;

   // A write is only eligible with a valid, non-empty FIFO head; on a CPU tie the
   // source not served last wins.
   assign wr_ok  = ~wr_empty & wr_valid;
   assign rd_win = rd_req & (~wr_ok | (last_cpu == LAST_WR));

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      last_cpu_nxt   = last_cpu;
      addr_nxt       = sram_addr;
      dq_out_nxt     = sram_dq_out;
      scan_data_nxt  = scan_data;
      rd_data_nxt    = rd_data;
      scan_valid_nxt = 1'b0;
      rd_done_nxt    = 1'b0;
      wr_read_nxt    = 1'b0;
      we_n_nxt       = 1'b1;
      ce_n_nxt       = 1'b1;
      oe_n_nxt       = 1'b1;
      dq_oe_nxt      = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (scan_req) begin
               state_nxt = SCAN_RD;
               addr_nxt  = scan_addr;
            end else if (rd_win) begin
               state_nxt    = CPU_RD;
               addr_nxt     = rd_addr;
               last_cpu_nxt = LAST_RD;
            end else if (wr_ok) begin
               state_nxt    = WR;
               addr_nxt     = wr_addr;
               dq_out_nxt   = wr_data;
               last_cpu_nxt = LAST_WR;
               wr_read_nxt  = 1'b1;
            end
         end
         SCAN_RD, CPU_RD: begin
            if (cnt == RD_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               if (state == SCAN_RD) begin
                  scan_data_nxt  = sram_dq_in;
                  scan_valid_nxt = 1'b1;
               end else begin
                  rd_data_nxt = sram_dq_in;
                  rd_done_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         WR: begin
            if (cnt == WR_LAST) begin
               state_nxt = WR_REC;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         WR_REC:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Strobes are decoded from the next state so every pin leaves a flop.
      case (state_nxt)
         SCAN_RD, CPU_RD: begin
            ce_n_nxt = 1'b0;
            oe_n_nxt = 1'b0;
         end
         WR: begin
            ce_n_nxt  = 1'b0;
            we_n_nxt  = 1'b0;
            dq_oe_nxt = 1'b1;
         end
         WR_REC: begin
            // WE has risen; keep driving data for hold time.
            ce_n_nxt  = 1'b0;
            dq_oe_nxt = 1'b1;
         end
         default: dq_out_nxt = '0;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         last_cpu    <= LAST_WR;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         wr_read     <= 1'b0;
         scan_valid  <= 1'b0;
         rd_done     <= 1'b0;
         scan_data   <= '0;
         rd_data     <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         last_cpu    <= last_cpu_nxt;
         sram_addr   <= addr_nxt;
         sram_dq_out <= dq_out_nxt;
         sram_dq_oe  <= dq_oe_nxt;
         sram_we_n   <= we_n_nxt;
         sram_ce_n   <= ce_n_nxt;
         sram_oe_n   <= oe_n_nxt;
         wr_read     <= wr_read_nxt;
         scan_valid  <= scan_valid_nxt;
         rd_done     <= rd_done_nxt;
         scan_data   <= scan_data_nxt;
         rd_data     <= rd_data_nxt;
         busy        <= (state_nxt != IDLE);
      end
   end
endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Bench for vram_bus_arbiter: pin-level SRAM model, FIFO/requester models and a
// transaction-level reference memory that predicts grants and read data.
module tb_vram_bus_arbiter;
   localparam int ADDR_W    = 19;
   localparam int DATA_W    = 16;
   localparam int WR_CYCLES = 3;
   localparam int RD_CYCLES = 2;
   localparam int MEM_SZ    = 1 << ADDR_W;

   logic              clock = 1'b0;
   logic              resetn = 1'b1;
   logic              scan_req = 1'b0, rd_req = 1'b0;
   logic [ADDR_W-1:0] scan_addr = '0, rd_addr = '0, wr_addr = '0;
   logic              wr_empty = 1'b1, wr_valid = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic [DATA_W-1:0] sram_dq_in = '0;
   logic [DATA_W-1:0] scan_data, rd_data, sram_dq_out;
   logic              scan_valid, rd_done, wr_read, sram_dq_oe;
   logic              sram_we_n, sram_ce_n, sram_oe_n, busy;
   logic [ADDR_W-1:0] sram_addr;

   bit [DATA_W-1:0] sram_mem [MEM_SZ];
   bit [DATA_W-1:0] ref_mem  [MEM_SZ];
   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wword_t;
   wword_t fifo[$];

   always #5 clock = ~clock;

   vram_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYCLES(WR_CYCLES),
                      .RD_CYCLES(RD_CYCLES)) dut (
      .clock(clock), .resetn(resetn),
      .scan_req(scan_req), .scan_addr(scan_addr), .scan_data(scan_data), .scan_valid(scan_valid),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
      .wr_empty(wr_empty), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_read(wr_read), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
      .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .busy(busy)
   );

   // Asynchronous SRAM: read data settles mid-cycle while CE/OE are low,
   // writes commit on the rising edge of WE with CE still low and the bus driven.
   always @(negedge clock)
      sram_dq_in <= (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : '0;
   always @(posedge sram_we_n)
      if (resetn === 1'b1 && sram_ce_n === 1'b0 && sram_dq_oe === 1'b1)
         sram_mem[sram_addr] = sram_dq_out;

   task automatic fifo_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wword_t w;
      w.a = a;
      w.d = d;
      fifo.push_back(w);
   endtask

   // A popped word is what the VRAM holds from then on.
   task automatic fifo_pop();
      wword_t w;
      if (fifo.size() > 0) begin
         w = fifo.pop_front();
         ref_mem[w.a] = w.d;
      end
   endtask

   task automatic fifo_drive(input bit jitter);
      wr_empty = (fifo.size() == 0);
      wr_valid = !wr_empty;
      if (jitter && ($urandom_range(0, 7) == 0)) wr_valid = ~wr_valid;
      if (!wr_empty) begin
         wr_addr = fifo[0].a;
         wr_data = fifo[0].d;
      end
   endtask

   task automatic apply_reset();
      resetn   = 1'b0;
      scan_req = 1'b0;
      rd_req   = 1'b0;
      fifo.delete();
      fifo_drive(0);
      repeat (2) @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      scan_req = 1'b1; scan_addr = 19'h40010;
      rd_req = 1'b1;   rd_addr = 19'h00020;
      wr_empty = 1'b0; wr_valid = 1'b1; wr_addr = 19'h00030; wr_data = 16'h1234;
      repeat (3) @(negedge clock);
      checks++;
      if ({sram_we_n, sram_ce_n, sram_oe_n} !== 3'b111) begin
         errors++; $display("FAIL reset_strobes: got %b want 111", {sram_we_n, sram_ce_n, sram_oe_n});
      end
      checks++;
      if ({sram_dq_oe, wr_read, scan_valid, rd_done, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 00000", {sram_dq_oe, wr_read, scan_valid, rd_done, busy});
      end
      checks++;
      if (sram_addr !== '0 || sram_dq_out !== '0) begin
         errors++; $display("FAIL reset_bus: got addr %h dq %h want 0 0", sram_addr, sram_dq_out);
      end
      checks++;
      if (scan_data !== '0 || rd_data !== '0) begin
         errors++; $display("FAIL reset_data: got scan %h rd %h want 0 0", scan_data, rd_data);
      end
      resetn = 1'b1;
      @(negedge clock);
      checks++;
      if (sram_ce_n !== 1'b0 || sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || sram_addr !== 19'h40010 || busy !== 1'b1) begin
         errors++; $display("FAIL reset_first_grant: got ce %b oe %b we %b addr %h want 0 0 1 40010", sram_ce_n, sram_oe_n, sram_we_n, sram_addr);
      end
      scan_req = 1'b0; rd_req = 1'b0; wr_empty = 1'b1; wr_valid = 1'b0;
      repeat (6) @(negedge clock);
   endtask

   task automatic test_single_write();
      int we_low = 0, oe_high = 0, pops = 0, pop_at = -1;
      apply_reset();
      fifo_push(19'h00123, 16'hBEEF);
      fifo_drive(0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         if (!sram_we_n) we_low++;
         if (sram_dq_oe) oe_high++;
         if (wr_read) begin
            pops++;
            if (pop_at < 0) pop_at = k;
            fifo_pop();
            fifo_drive(0);
         end
      end
      checks++;
      if (we_low != WR_CYCLES) begin errors++; $display("FAIL wr_we_cycles: got %0d want %0d", we_low, WR_CYCLES); end
      checks++;
      if (pops != 1 || pop_at != 1) begin errors++; $display("FAIL wr_pop: got %0d pops at %0d want 1 at 1", pops, pop_at); end
      checks++;
      if (oe_high != WR_CYCLES + 1) begin errors++; $display("FAIL wr_dq_oe_cycles: got %0d want %0d", oe_high, WR_CYCLES + 1); end
      checks++;
      if (sram_mem[19'h00123] !== 16'hBEEF) begin errors++; $display("FAIL wr_mem: got %h want beef", sram_mem[19'h00123]); end
   endtask

   task automatic test_priority();
      logic [ADDR_W-1:0] seq_a[$];
      bit seq_w[$];
      bit prev_ce = 1'b1;
      int overlap = 0;
      apply_reset();
      scan_addr = 19'h40005; scan_req = 1'b1;
      rd_addr   = 19'h00007; rd_req   = 1'b1;
      fifo_push(19'h00009, 16'hA55A);
      fifo_drive(0);
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (!sram_we_n && !sram_oe_n) overlap++;
         if (!sram_ce_n && prev_ce) begin
            seq_a.push_back(sram_addr);
            seq_w.push_back(!sram_we_n);
         end
         prev_ce = sram_ce_n;
         if (scan_valid) begin
            checks++;
            if (scan_data !== ref_mem[scan_addr]) begin errors++; $display("FAIL prio_scan_data: got %h want %h", scan_data, ref_mem[scan_addr]); end
            scan_req = 1'b0;
         end
         if (rd_done) begin
            checks++;
            if (rd_data !== ref_mem[rd_addr]) begin errors++; $display("FAIL prio_rd_data: got %h want %h", rd_data, ref_mem[rd_addr]); end
            rd_req = 1'b0;
         end
         if (wr_read) begin fifo_pop(); fifo_drive(0); end
      end
      checks++;
      if (seq_a.size() != 3 || seq_a[0] !== 19'h40005 || seq_w[0] || seq_a[1] !== 19'h00007 || seq_w[1]
          || seq_a[2] !== 19'h00009 || !seq_w[2]) begin
         errors++; $display("FAIL prio_order: got %0d separate accesses, want scan 40005, read 00007, write 00009", seq_a.size());
      end
      checks++;
      if (overlap != 0) begin errors++; $display("FAIL prio_overlap: got %0d cycles want 0", overlap); end
      checks++;
      if (sram_mem[19'h00009] !== 16'hA55A) begin errors++; $display("FAIL prio_wr_mem: got %h want a55a", sram_mem[19'h00009]); end
   endtask

   task automatic test_round_robin();
      bit kinds[$];
      bit prev_ce = 1'b1;
      apply_reset();
      rd_addr = 19'h00100; rd_req = 1'b1;
      for (int i = 0; i < 4; i++) fifo_push(19'h00200 + 19'(i), 16'($urandom));
      fifo_drive(0);
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         if (!sram_ce_n && prev_ce) kinds.push_back(!sram_we_n);
         prev_ce = sram_ce_n;
         if (rd_done) begin
            checks++;
            if (rd_data !== ref_mem[rd_addr]) begin errors++; $display("FAIL rr_rd_data: got %h want %h at %h", rd_data, ref_mem[rd_addr], rd_addr); end
            rd_addr = rd_addr + 19'd1;
         end
         if (wr_read) begin fifo_pop(); fifo_drive(0); end
      end
      rd_req = 1'b0;
      repeat (6) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= kinds.size() || kinds[i] !== bit'(i % 2)) begin
            errors++; $display("FAIL rr_grant%0d: got write=%b want write=%b", i, (i < kinds.size()) ? kinds[i] : 1'bx, bit'(i % 2));
         end
      end
   endtask

   task automatic test_fifo_gating();
      int pops_a = 0, we_a = 0, pops_b = 0, we_b = 0;
      apply_reset();
      wr_empty = 1'b1; wr_valid = 1'b1; wr_addr = 19'h00055; wr_data = 16'hDEAD;
      repeat (20) begin
         @(negedge clock);
         if (wr_read) pops_a++;
         if (!sram_we_n) we_a++;
      end
      wr_empty = 1'b0; wr_valid = 1'b0;
      repeat (20) begin
         @(negedge clock);
         if (wr_read) pops_b++;
         if (!sram_we_n) we_b++;
      end
      wr_empty = 1'b1;
      checks++;
      if (pops_a != 0 || we_a != 0) begin errors++; $display("FAIL gate_empty: got %0d pops %0d we cycles want 0 0", pops_a, we_a); end
      checks++;
      if (pops_b != 0 || we_b != 0) begin errors++; $display("FAIL gate_invalid: got %0d pops %0d we cycles want 0 0", pops_b, we_b); end
   endtask

   task automatic test_reset_mid_write();
      int we_low = 0, pops = 0;
      wword_t lost;
      apply_reset();
      fifo_push(19'h00300, 16'h1111);
      fifo_push(19'h00301, 16'h2222);
      fifo_drive(0);
      @(negedge clock);
      checks++;
      if (wr_read !== 1'b1 || sram_we_n !== 1'b0) begin errors++; $display("FAIL midwr_start: got pop %b we %b want 1 0", wr_read, sram_we_n); end
      lost = fifo.pop_front();
      fifo_drive(0);
      @(negedge clock);
      resetn = 1'b0;
      #1;
      checks++;
      if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
         errors++; $display("FAIL midwr_abort: got we %b ce %b dq_oe %b want 1 1 0", sram_we_n, sram_ce_n, sram_dq_oe);
      end
      @(negedge clock);
      resetn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (!sram_we_n) we_low++;
         if (wr_read) begin pops++; fifo_pop(); fifo_drive(0); end
      end
      checks++;
      if (we_low != WR_CYCLES || pops != 1) begin errors++; $display("FAIL midwr_resume: got %0d we cycles %0d pops want %0d 1", we_low, pops, WR_CYCLES); end
      checks++;
      if (sram_mem[19'h00301] !== 16'h2222) begin errors++; $display("FAIL midwr_mem: got %h want 2222 (lost word %h)", sram_mem[19'h00301], lost.d); end
   endtask

   task automatic test_random_traffic(input int ncyc);
      bit prev_ce = 1'b1;
      bit last_wr = 1'b1;
      bit s, r, w;
      int exp_kind;
      logic [ADDR_W-1:0] exp_a;
      logic [ADDR_W-1:0] touched[$];
      apply_reset();
      for (int k = 0; k < ncyc + 200; k++) begin
         @(negedge clock);
         // The DUT was idle last cycle, so it must have granted from the inputs it just sampled.
         if (prev_ce) begin
            s = scan_req;
            r = rd_req;
            w = !wr_empty && wr_valid;
            exp_kind = s ? 0 : (r && (!w || last_wr)) ? 1 : w ? 2 : 3;
            exp_a = (exp_kind == 0) ? scan_addr : (exp_kind == 1) ? rd_addr : wr_addr;
            checks++;
            if (exp_kind == 3) begin
               if (sram_ce_n !== 1'b1) begin errors++; $display("FAIL rand_spurious_grant: got ce %b want 1 at cycle %0d", sram_ce_n, k); end
            end else if (sram_ce_n !== 1'b0 || sram_addr !== exp_a || sram_we_n !== (exp_kind != 2)
                         || (exp_kind == 2 && sram_dq_out !== wr_data)) begin
               errors++; $display("FAIL rand_grant: got ce %b we %b addr %h want kind %0d addr %h at cycle %0d", sram_ce_n, sram_we_n, sram_addr, exp_kind, exp_a, k);
            end
            if (exp_kind == 1) last_wr = 1'b0;
            else if (exp_kind == 2) last_wr = 1'b1;
         end
         prev_ce = sram_ce_n;
         checks++;
         if ((!sram_we_n && !sram_oe_n) || (sram_dq_oe && !sram_oe_n) || busy !== !sram_ce_n) begin
            errors++; $display("FAIL rand_protocol: got we %b oe %b dq_oe %b busy %b ce %b at cycle %0d", sram_we_n, sram_oe_n, sram_dq_oe, busy, sram_ce_n, k);
         end
         if (scan_valid) begin
            checks++;
            if (!scan_req || scan_data !== ref_mem[scan_addr]) begin
               errors++; $display("FAIL rand_scan_data: got %h want %h at %h", scan_data, ref_mem[scan_addr], scan_addr);
            end
            scan_req = 1'b0;
         end
         if (rd_done) begin
            checks++;
            if (!rd_req || rd_data !== ref_mem[rd_addr]) begin
               errors++; $display("FAIL rand_rd_data: got %h want %h at %h", rd_data, ref_mem[rd_addr], rd_addr);
            end
            rd_req = 1'b0;
         end
         if (wr_read) begin
            checks++;
            if (fifo.size() == 0) begin errors++; $display("FAIL rand_pop: got pop with empty FIFO want none"); end
            else begin touched.push_back(fifo[0].a); fifo_pop(); end
         end
         if (k < ncyc) begin
            if (!scan_req && $urandom_range(0, 99) < 15) begin
               scan_req = 1'b1; scan_addr = 19'h40000 | 19'($urandom_range(0, 15));
            end
            if (!rd_req && $urandom_range(0, 99) < 30) begin
               rd_req = 1'b1; rd_addr = 19'($urandom_range(0, 15));
            end
            if (fifo.size() < 6 && $urandom_range(0, 99) < 35)
               fifo_push(($urandom_range(0, 1) ? 19'h40000 : 19'h0) | 19'($urandom_range(0, 15)), 16'($urandom));
            fifo_drive(1);
         end else begin
            fifo_drive(0);
         end
      end
      checks++;
      if (fifo.size() != 0 || scan_req || rd_req) begin
         errors++; $display("FAIL rand_drain: got fifo %0d scan %b rd %b want 0 0 0", fifo.size(), scan_req, rd_req);
      end
      foreach (touched[i]) begin
         checks++;
         if (sram_mem[touched[i]] !== ref_mem[touched[i]]) begin
            errors++; $display("FAIL rand_mem: got %h want %h at %h", sram_mem[touched[i]], ref_mem[touched[i]], touched[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < MEM_SZ; i++) begin
         sram_mem[i] = 16'(i) ^ 16'h5A5A;
         ref_mem[i]  = 16'(i) ^ 16'h5A5A;
      end
      #2 resetn = 1'b0;
      test_reset();
      test_single_write();
      test_priority();
      test_round_robin();
      test_fifo_gating();
      test_reset_mid_write();
      test_random_traffic(1500);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
